// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/complete sequencer.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_TAG_W = 5;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef struct packed {
    logic                 valid;
    logic [DIV_TAG_W-1:0] tag;
    logic                 is_rem;
    logic                 neg_q;
    logic                 neg_r;
  } div_shadow_t;

endpackage

// File: rtl/div_result_fifo.sv
// In-order result buffer between the divider completion point and writeback.
module div_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  // Empty head reads as zero so the result port is clean out of reset.
  assign rdata  = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; only pointers and count
  // carry state that matters, and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Issue/complete controller for the fixed-latency pipelined unsigned divider.
// Optional perf counters enabled by defining DIV_SEQ_PERF_COUNTERS_EN.
module div_sequencer
  import div_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = DIV_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DIV_XLEN-1:0] in_a,
  input  logic [DIV_XLEN-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [DIV_XLEN-1:0] div_dividend,
  output logic [DIV_XLEN-1:0] div_divisor,
  input  logic [DIV_XLEN-1:0] div_quotient,
  input  logic [DIV_XLEN-1:0] div_remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIV_XLEN-1:0] out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
`ifdef DIV_SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stalls
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(LATENCY+1);

  // The shadow entry's tag field is sized by the package.
  if (TAG_W != DIV_TAG_W) begin : g_tag_w_check
    $error("div_sequencer: TAG_W must equal div_pkg::DIV_TAG_W");
  end

  div_op_e       op;
  logic          is_signed;
  logic          is_rem;
  logic          accept;
  div_shadow_t   entry;
  div_shadow_t   shadow [LATENCY];
  div_shadow_t   last;
  logic [LW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [31:0]   outstanding;
  logic [DIV_XLEN-1:0] res_mag;
  logic [DIV_XLEN-1:0] result;
  logic          res_neg;

  assign op        = div_op_e'(in_op);
  assign is_signed = (op == DIV) || (op == REM);
  assign is_rem    = (op == REM) || (op == REMU);

  // Credits cover both the divider pipeline and the FIFO, so a completing
  // result always finds a free slot even though the divider cannot stall.
  assign outstanding = 32'(inflight) + 32'(fifo_count);
  assign in_ready    = outstanding < 32'(DEPTH);
  assign busy        = outstanding != '0;
  assign accept      = in_valid && in_ready;

  assign div_dividend = (is_signed && in_a[DIV_XLEN-1]) ? -in_a : in_a;
  assign div_divisor  = (is_signed && in_b[DIV_XLEN-1]) ? -in_b : in_b;

  always_comb begin
    entry        = '0;
    entry.valid  = accept;
    entry.tag    = in_tag;
    entry.is_rem = is_rem;
    entry.neg_q  = is_signed && (in_a[DIV_XLEN-1] ^ in_b[DIV_XLEN-1]) && (in_b != '0);
    entry.neg_r  = is_signed && in_a[DIV_XLEN-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) shadow[i] <= '0;
    end else begin
      shadow[0] <= entry;
      for (int i = 1; i < LATENCY; i++) shadow[i] <= shadow[i-1];
    end
  end

  assign last = shadow[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, last.valid})
        2'b10:   inflight <= inflight + LW'(1);
        2'b01:   inflight <= inflight - LW'(1);
        default: ;
      endcase
    end
  end

  // Divide-by-zero and signed overflow fall out of the unsigned divider's
  // results combined with these sign fixups.
  assign res_mag = last.is_rem ? div_remainder : div_quotient;
  assign res_neg = last.is_rem ? last.neg_r : last.neg_q;
  assign result  = res_neg ? -res_mag : res_mag;

  assign out_valid = fifo_count != '0;

  div_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DIV_XLEN + TAG_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (last.valid),
    .wdata ({result, last.tag}),
    .pop   (out_valid && out_ready),
    .rdata ({out_result, out_tag}),
    .count (fifo_count)
  );

`ifdef DIV_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept)                 perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready)  perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural divider and reference model.
module tb_div_sequencer;

  localparam int LATENCY = 8;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      div_dividend, div_divisor, div_quotient, div_remainder;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef DIV_SEQ_PERF_COUNTERS_EN
  logic [31:0]      perf_issued, perf_stalls;
`endif

  always #5 clk = ~clk;

  div_sequencer #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .busy          (busy)
`ifdef DIV_SEQ_PERF_COUNTERS_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stalls   (perf_stalls)
`endif
  );

  // Fixed-latency unsigned divider: x/0 gives all-ones quotient, remainder x.
  logic [31:0] q_pipe [LATENCY];
  logic [31:0] r_pipe [LATENCY];
  always @(posedge clk) begin
    q_pipe[0] <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
    r_pipe[0] <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
    for (int i = 1; i < LATENCY; i++) begin
      q_pipe[i] <= q_pipe[i-1];
      r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign div_quotient  = q_pipe[LATENCY-1];
  assign div_remainder = r_pipe[LATENCY-1];

  // RISC-V M-extension semantics from plain signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one request for one cycle; acceptance is known from in_ready before the edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    #1;
    acc = in_ready;
    if (acc) sb_q.push_back('{exp, tag});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_complete", (sb_q.size() == 0 && !busy), 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2 out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold during stalls.
  bit               prev_stall = 0;
  logic [31:0]      prev_res;
  logic [TAG_W-1:0] prev_tag;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", {out_result, out_tag}, {prev_res, prev_tag});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", out_valid, 0);
          end else begin
            e = sb_q.pop_front();
            check("result", out_result, e.res);
            check("tag", out_tag, e.tag);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_tag   = out_tag;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int accepted, first_reject, seen_valid;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [TAG_W-1:0] tag;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Latency: DIVU 100/7 accepted at posedge N, out_valid after posedge N+LATENCY.
    issue(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, acc);
    check("lat_accept", acc, 1);
    for (int k = 1; k <= LATENCY; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_valid_%0d", k), out_valid, (k == LATENCY));
    end
    wait_drain();

    // Sign fixups and special cases.
    issue(2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          acc);
    issue(2'b00, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  acc);
    issue(2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  acc);
    issue(2'b10, 32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          acc);
    issue(2'b00, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF,  acc);
    issue(2'b11, 32'd5,          32'd0,          5'd9,  32'd5,          acc);
    issue(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  acc);
    issue(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          acc);
    issue(2'b10, 32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFB,  acc);
    wait_drain();

    // Credit limit with the consumer stalled.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    accepted = 0;
    first_reject = -1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      issue(2'b01, a, b, 5'(i), a / b, acc);
      if (acc) accepted++;
      else if (first_reject < 0) first_reject = i;
    end
    check("bp_accepted", accepted, DEPTH);
    check("bp_first_reject", first_reject, DEPTH);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_busy", busy, 1);
    ready_mode = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_still_low", in_ready, 0);
    check("bp_out_ready", out_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_back", in_ready, 1);
    wait_drain();

    // Random issue against random backpressure.
    ready_mode = 2;
    tag = '0;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      acc = 0;
      for (int t = 0; t < 200 && !acc; t++) issue(op, a, b, tag, ref_result(op, a, b), acc);
      check("rand_issue_accepted", acc, 1);
      tag = tag + 1'b1;
    end
    ready_mode = 1;
    wait_drain();

    // Reset with 2 buffered and 3 in flight.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) issue(2'b01, 32'd50, 32'd5, 5'(20 + i), 32'd10, acc);
    repeat (LATENCY + 2) @(negedge clk);
    for (int i = 0; i < 3; i++) issue(2'b01, 32'd60, 32'd6, 5'(22 + i), 32'd10, acc);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    seen_valid = 0;
    repeat (LATENCY + 6) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("post_rst_no_stale", seen_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
